// File: rtl/ysyx_24100005_wbu_pkg.sv
// Shared constants for the writeback unit: load funct3 encodings and the
// architectural register count.
package ysyx_24100005_wbu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int unsigned NREG = 32;

endpackage

// File: rtl/ysyx_24100005_Reg.sv
// Generic flop template: synchronous active-high reset to RESET_VAL,
// load on wen.
module ysyx_24100005_Reg #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  always_ff @(posedge clk) begin
    if (rst)      dout <= RESET_VAL;
    else if (wen) dout <= din;
  end

endmodule

// File: rtl/ysyx_24100005_load_ext.sv
// Combinational load extender: picks the byte/half lane from an aligned
// memory word and sign- or zero-extends it according to funct3.
module ysyx_24100005_load_ext
  import ysyx_24100005_wbu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            addr_lo,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = data[{addr_lo, 3'b000} +: 8];
    // Halfword lane ignores addr_lo[0]; misaligned halves read the aligned half.
    half_lane = data[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   result = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
      F3_LBU:  result = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
      F3_LH:   result = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
      F3_LHU:  result = {{(DATA_WIDTH-16){1'b0}}, half_lane};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/ysyx_24100005_wbu.sv
// Writeback unit: arbitrates EXU/LSU results into one registered RF write per
// cycle and tracks a busy scoreboard. Optional WBU_BYPASS_EN adds fwd_* ports.
module ysyx_24100005_wbu
  import ysyx_24100005_wbu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned LSU_PRIO   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exu_valid,
  output logic                     exu_ready,
  input  logic [ADDR_WIDTH-1:0]    exu_rd,
  input  logic [DATA_WIDTH-1:0]    exu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDR_WIDTH-1:0]    lsu_rd,
  input  logic [DATA_WIDTH-1:0]    lsu_data,
  input  logic [1:0]               lsu_addr_lo,
  input  logic [2:0]               lsu_funct3,
  input  logic                     alloc_valid,
  input  logic [ADDR_WIDTH-1:0]    alloc_rd,
  output logic [2**ADDR_WIDTH-1:0] busy,
  output logic                     rf_wen,
  output logic [ADDR_WIDTH-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
`ifdef WBU_BYPASS_EN
  input  logic [ADDR_WIDTH-1:0]    fwd_rs1addr,
  input  logic [ADDR_WIDTH-1:0]    fwd_rs2addr,
  output logic                     fwd_rs1hit,
  output logic                     fwd_rs2hit,
  output logic [DATA_WIDTH-1:0]    fwd_rs1data,
  output logic [DATA_WIDTH-1:0]    fwd_rs2data,
`endif
  output logic [CNT_WIDTH-1:0]     retire_cnt
);

  logic [DATA_WIDTH-1:0]    load_data;
  logic                     accept;
  logic [ADDR_WIDTH-1:0]    sel_rd;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic                     wr_next;
  logic [2**ADDR_WIDTH-1:0] busy_next;

  ysyx_24100005_load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
    .data    (lsu_data),
    .addr_lo (lsu_addr_lo),
    .funct3  (lsu_funct3),
    .result  (load_data)
  );

  // Readies are forced low during reset so nothing is consumed while flushing.
  always_comb begin
    lsu_ready = !rst && lsu_valid && (!exu_valid || (LSU_PRIO != 0));
    exu_ready = !rst && exu_valid && (!lsu_valid || (LSU_PRIO == 0));
    accept    = lsu_ready || exu_ready;
    sel_rd    = lsu_ready ? lsu_rd    : exu_rd;
    sel_data  = lsu_ready ? load_data : exu_data;
    wr_next   = accept && (sel_rd != '0);
  end

  ysyx_24100005_Reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_wen_reg (
    .clk (clk), .rst (rst), .din (wr_next), .dout (rf_wen), .wen (1'b1)
  );

  ysyx_24100005_Reg #(.WIDTH(ADDR_WIDTH), .RESET_VAL('0)) u_waddr_reg (
    .clk (clk), .rst (rst), .din (sel_rd), .dout (rf_waddr), .wen (wr_next)
  );

  ysyx_24100005_Reg #(.WIDTH(DATA_WIDTH), .RESET_VAL('0)) u_wdata_reg (
    .clk (clk), .rst (rst), .din (sel_data), .dout (rf_wdata), .wen (wr_next)
  );

  // Clear first, then set, so an allocation in the write cycle keeps the bit.
  always_comb begin
    busy_next = busy;
    if (rf_wen) busy_next[rf_waddr] = 1'b0;
    if (alloc_valid && (alloc_rd != '0)) busy_next[alloc_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      retire_cnt <= '0;
    end else begin
      busy <= busy_next;
      if (accept) retire_cnt <= retire_cnt + CNT_WIDTH'(1);
    end
  end

`ifdef WBU_BYPASS_EN
  always_comb begin
    fwd_rs1hit  = rf_wen && (rf_waddr == fwd_rs1addr) && (fwd_rs1addr != '0);
    fwd_rs2hit  = rf_wen && (rf_waddr == fwd_rs2addr) && (fwd_rs2addr != '0);
    fwd_rs1data = fwd_rs1hit ? rf_wdata : '0;
    fwd_rs2data = fwd_rs2hit ? rf_wdata : '0;
  end
`endif

endmodule

// File: tb/tb_ysyx_24100005_wbu.sv
// Self-checking bench for ysyx_24100005_wbu: directed cases plus randomized
// traffic checked against a cycle-level behavioural model.
module tb_ysyx_24100005_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        exu_valid, lsu_valid, alloc_valid;
  logic        exu_ready, lsu_ready;
  logic [4:0]  exu_rd, lsu_rd, alloc_rd;
  logic [31:0] exu_data, lsu_data;
  logic [1:0]  lsu_addr_lo;
  logic [2:0]  lsu_funct3;
  logic [31:0] busy;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  retire_cnt;
`ifdef WBU_BYPASS_EN
  logic [4:0]  fwd_rs1addr, fwd_rs2addr;
  logic        fwd_rs1hit, fwd_rs2hit;
  logic [31:0] fwd_rs1data, fwd_rs2data;
`endif

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  // Reference model state
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_busy;
  int unsigned m_cnt;
  logic        last_er, last_lr;

  always #5 clk = ~clk;

  ysyx_24100005_wbu #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .CNT_WIDTH  (4),
    .LSU_PRIO   (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .exu_valid   (exu_valid),
    .exu_ready   (exu_ready),
    .exu_rd      (exu_rd),
    .exu_data    (exu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .lsu_addr_lo (lsu_addr_lo),
    .lsu_funct3  (lsu_funct3),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .busy        (busy),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
`ifdef WBU_BYPASS_EN
    .fwd_rs1addr (fwd_rs1addr),
    .fwd_rs2addr (fwd_rs2addr),
    .fwd_rs1hit  (fwd_rs1hit),
    .fwd_rs2hit  (fwd_rs2hit),
    .fwd_rs1data (fwd_rs1data),
    .fwd_rs2data (fwd_rs2data),
`endif
    .retire_cnt  (retire_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Load extension from the ISA rules: shift the lane down, mask, extend.
  function automatic logic [31:0] ext_model(input logic [31:0] w, input int unsigned off,
                                            input int unsigned f3);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      0:       return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
      4:       return b;
      1:       return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      5:       return h;
      default: return w;
    endcase
  endfunction

  // One clock cycle: check readies against the inputs, advance the model,
  // then check registered outputs after the edge.
  task automatic step();
    logic        er, lr, acc;
    logic [4:0]  rd;
    logic [31:0] d;
`ifdef WBU_BYPASS_EN
    fwd_rs1addr = m_waddr;
    fwd_rs2addr = 5'($urandom_range(0, 31));
`endif
    #1;
    lr = !rst && lsu_valid;
    er = !rst && exu_valid && !lsu_valid;
    check("exu_ready", 64'(exu_ready), 64'(er));
    check("lsu_ready", 64'(lsu_ready), 64'(lr));
`ifdef WBU_BYPASS_EN
    check("fwd_rs1hit", 64'(fwd_rs1hit), 64'(m_wen && m_waddr == fwd_rs1addr && fwd_rs1addr != 0));
    check("fwd_rs1data", 64'(fwd_rs1data),
          64'((m_wen && m_waddr == fwd_rs1addr && fwd_rs1addr != 0) ? m_wdata : 32'h0));
    check("fwd_rs2hit", 64'(fwd_rs2hit), 64'(m_wen && m_waddr == fwd_rs2addr && fwd_rs2addr != 0));
    check("fwd_rs2data", 64'(fwd_rs2data),
          64'((m_wen && m_waddr == fwd_rs2addr && fwd_rs2addr != 0) ? m_wdata : 32'h0));
`endif
    acc = er || lr;
    rd  = lr ? lsu_rd : exu_rd;
    d   = lr ? ext_model(lsu_data, lsu_addr_lo, lsu_funct3) : exu_data;
    last_er = er;
    last_lr = lr;
    if (rst) begin
      m_wen = 0; m_waddr = 0; m_wdata = 0; m_busy = 0; m_cnt = 0;
    end else begin
      if (m_wen) m_busy[m_waddr] = 1'b0;
      if (alloc_valid && alloc_rd != 0) m_busy[alloc_rd] = 1'b1;
      m_wen = acc && rd != 0;
      if (m_wen) begin
        m_waddr = rd;
        m_wdata = d;
      end
      if (acc) m_cnt = (m_cnt + 1) % 16;
    end
    @(posedge clk);
    #1;
    check("rf_wen", 64'(rf_wen), 64'(m_wen));
    if (m_wen || rst) begin
      check("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
      check("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    end
    check("busy", 64'(busy), 64'(m_busy));
    check("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
  endtask

  task automatic idle();
    exu_valid = 0; lsu_valid = 0; alloc_valid = 0;
  endtask

  task automatic load_chk(input string tag, input logic [1:0] off, input logic [2:0] f3,
                          input logic [31:0] exp);
    lsu_valid = 1; lsu_rd = 5'd10; lsu_data = 32'h80FF_7F01;
    lsu_addr_lo = off; lsu_funct3 = f3;
    step();
    idle();
    check(tag, 64'(rf_wdata), 64'(exp));
  endtask

  initial begin
    rst = 1; idle();
    exu_rd = 0; exu_data = 0; lsu_rd = 0; lsu_data = 0; lsu_addr_lo = 0;
    lsu_funct3 = 0; alloc_rd = 0;
    m_wen = 0; m_waddr = 0; m_wdata = 0; m_busy = 0; m_cnt = 0;
    last_er = 0; last_lr = 0;
    step(); step();
    rst = 0;

    // Single EXU result
    exu_valid = 1; exu_rd = 5; exu_data = 32'h1234;
    step(); idle();
    check("t1_waddr", 64'(rf_waddr), 64'd5);
    check("t1_wdata", 64'(rf_wdata), 64'h1234);
    check("t1_cnt", 64'(retire_cnt), 64'd1);
    step();

    // Simultaneous requests: LSU first, EXU held, written next
    exu_valid = 1; exu_rd = 3; exu_data = 32'hAAAA;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h5555; lsu_funct3 = 3'b010; lsu_addr_lo = 0;
    step();
    check("t2_first", 64'(rf_waddr), 64'd4);
    lsu_valid = 0;
    step(); idle();
    check("t2_second", 64'(rf_waddr), 64'd3);
    check("t2_wen", 64'(rf_wen), 64'd1);
    step();

    // Load extension
    load_chk("lb_off1",  2'd1, 3'b000, 32'h0000_007F);
    load_chk("lb_off2",  2'd2, 3'b000, 32'hFFFF_FFFF);
    load_chk("lbu_off3", 2'd3, 3'b100, 32'h0000_0080);
    load_chk("lh_off2",  2'd2, 3'b001, 32'hFFFF_80FF);
    load_chk("lhu_off0", 2'd0, 3'b101, 32'h0000_7F01);
    step();

    // Scoreboard set, then cleared by writeback
    alloc_valid = 1; alloc_rd = 7;
    step(); idle();
    check("sb_set", 64'(busy[7]), 64'd1);
    exu_valid = 1; exu_rd = 7; exu_data = 32'h77;
    step(); idle();
    check("sb_held", 64'(busy[7]), 64'd1);
    step();
    check("sb_clear", 64'(busy[7]), 64'd0);

    // Set wins over simultaneous clear
    exu_valid = 1; exu_rd = 7;
    step(); idle();
    alloc_valid = 1; alloc_rd = 7;
    step(); idle();
    check("sb_setwins", 64'(busy[7]), 64'd1);
    step();

    // rd==0 accepted and counted, counter wraps 15 -> 0
    rst = 1; step(); rst = 0;
    exu_valid = 1; exu_rd = 0; exu_data = 32'hDEAD;
    for (int i = 0; i < 15; i++) step();
    check("cnt15", 64'(retire_cnt), 64'd15);
    check("rd0_nowen", 64'(rf_wen), 64'd0);
    step(); idle();
    check("cnt_wrap", 64'(retire_cnt), 64'd0);
    check("busy0", 64'(busy[0]), 64'd0);

    // Reset with a staged write
    exu_valid = 1; exu_rd = 9; exu_data = 32'h99;
    step();
    check("pre_rst_wen", 64'(rf_wen), 64'd1);
    rst = 1; lsu_valid = 1; lsu_rd = 2;
    step();
    check("rst_wen", 64'(rf_wen), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cnt", 64'(retire_cnt), 64'd0);
    rst = 0; idle();
    step();

    // Randomized traffic; a source that was not accepted holds its request.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!(exu_valid && !last_er)) begin
        exu_valid = $urandom_range(0, 2) != 0;
        exu_rd    = 5'($urandom_range(0, 31));
        exu_data  = $urandom;
      end
      if (!(lsu_valid && !last_lr)) begin
        lsu_valid   = $urandom_range(0, 2) == 0;
        lsu_rd      = 5'($urandom_range(0, 31));
        lsu_data    = $urandom;
        lsu_addr_lo = 2'($urandom_range(0, 3));
        lsu_funct3  = 3'($urandom_range(0, 7));
      end
      alloc_valid = $urandom_range(0, 1) != 0;
      alloc_rd    = 5'($urandom_range(0, 31));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
